// File: rtl/axi4_monitor_pkg.sv
// Shared types and constants for the passive AXI4 transaction monitor.
package axi4_monitor_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  localparam int ERR_WLAST         = 0;
  localparam int ERR_RLAST         = 1;
  localparam int ERR_ORPHAN_B      = 2;
  localparam int ERR_ORPHAN_R      = 3;
  localparam int ERR_OVERFLOW      = 4;
  localparam int ERR_RLAST_MISSING = 5;
  localparam int ERR_W             = 6;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle; the monitor modport observes every signal as an input.
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
) ();
  logic [ID_W-1:0]   awid;   logic [ADDR_W-1:0] awaddr; logic [7:0] awlen;
  logic              awvalid; logic awready;
  logic [DATA_W-1:0] wdata;  logic wlast; logic wvalid; logic wready;
  logic [ID_W-1:0]   bid;    logic [1:0] bresp; logic bvalid; logic bready;
  logic [ID_W-1:0]   arid;   logic [ADDR_W-1:0] araddr; logic [7:0] arlen;
  logic              arvalid; logic arready;
  logic [ID_W-1:0]   rid;    logic [DATA_W-1:0] rdata; logic [1:0] rresp;
  logic              rlast;  logic rvalid; logic rready;

  modport monitor (
    input awid, awaddr, awlen, awvalid, awready,
    input wdata, wlast, wvalid, wready,
    input bid, bresp, bvalid, bready,
    input arid, araddr, arlen, arvalid, arready,
    input rid, rdata, rresp, rlast, rvalid, rready
  );
endinterface

// File: rtl/axi4_mon_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
module axi4_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTRW-1:0] rd_q, wr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign ovf_o   = push_i && full_o && !do_pop;
  assign dout_o  = mem_q[rd_q];

  function automatic logic [PTRW-1:0] nxt(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/axi4_txn_monitor.sv
// Passive AXI4 monitor: pairs AW with W bursts, tracks B/R per ID, flags protocol errors.
module axi4_txn_monitor
  import axi4_monitor_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 128,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING    = 8,
  parameter int MAX_PER_ID         = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi4_if.monitor                  monitor,
  input  logic                     err_clr,
  output logic                     wr_done,
  output logic [AXI4_ID_WIDTH-1:0] wr_done_id,
  output logic [1:0]               wr_done_resp,
  output logic                     rd_done,
  output logic [AXI4_ID_WIDTH-1:0] rd_done_id,
  output logic [1:0]               rd_done_resp,
  output logic [ERR_W-1:0]         err
);
  localparam int NID = 1 << AXI4_ID_WIDTH;
  localparam int PW  = $clog2(MAX_PER_ID + 1);

  typedef struct packed {
    logic [AXI4_ID_WIDTH-1:0] id;
    logic [7:0]               len;
  } aw_ent_t;

  logic [AXI4_ADDRESS_WIDTH-1:0] unused_addr;
  logic [AXI4_DATA_WIDTH-1:0]    unused_data;
  logic                          unused_aw_full, unused_wb_full;
  logic [NID-1:0]                unused_ar_full;
  assign unused_addr = monitor.awaddr ^ monitor.araddr;
  assign unused_data = monitor.wdata ^ monitor.rdata;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = monitor.awvalid && monitor.awready;
  assign w_hs  = monitor.wvalid  && monitor.wready;
  assign b_hs  = monitor.bvalid  && monitor.bready;
  assign ar_hs = monitor.arvalid && monitor.arready;
  assign r_hs  = monitor.rvalid  && monitor.rready;

  // Write path: AW and completed W bursts queue independently, then pair up.
  aw_ent_t    aw_din, aw_head;
  logic [8:0] w_cnt_q, wb_head;
  logic       aw_empty, wb_empty, aw_ovf, wb_ovf, pair;
  assign aw_din = '{id: monitor.awid, len: monitor.awlen};
  assign pair   = !aw_empty && !wb_empty;

  axi4_mon_fifo #(.WIDTH($bits(aw_ent_t)), .DEPTH(MAX_OUTSTANDING)) u_aw_fifo (
    .clk_i(clk), .rstn_i(rstn), .push_i(aw_hs), .din_i(aw_din), .pop_i(pair),
    .dout_o(aw_head), .full_o(unused_aw_full), .empty_o(aw_empty), .ovf_o(aw_ovf));

  axi4_mon_fifo #(.WIDTH(9), .DEPTH(MAX_OUTSTANDING)) u_wb_fifo (
    .clk_i(clk), .rstn_i(rstn), .push_i(w_hs && monitor.wlast), .din_i(w_cnt_q + 9'd1),
    .pop_i(pair), .dout_o(wb_head), .full_o(unused_wb_full), .empty_o(wb_empty), .ovf_o(wb_ovf));

  logic [NID-1:0][PW-1:0] b_pend_q, b_pend_d;
  logic b_ok, orphan_b, bpend_ovf, wlen_err;

  always_comb begin
    b_pend_d  = b_pend_q;
    b_ok      = 1'b0;
    orphan_b  = 1'b0;
    bpend_ovf = 1'b0;
    wlen_err  = pair && (wb_head != {1'b0, aw_head.len} + 9'd1);
    if (b_hs) begin
      if (b_pend_q[monitor.bid] == '0) orphan_b = 1'b1;
      else begin
        b_ok = 1'b1;
        b_pend_d[monitor.bid] = b_pend_q[monitor.bid] - PW'(1);
      end
    end
    // A same-cycle B on the same ID frees the slot, so the increment still fits.
    if (pair) begin
      if (b_pend_q[aw_head.id] == PW'(MAX_PER_ID) && !(b_ok && monitor.bid == aw_head.id))
        bpend_ovf = 1'b1;
      else
        b_pend_d[aw_head.id] = b_pend_d[aw_head.id] + PW'(1);
    end
  end

  // Read path: one ARLEN queue per ID so R beats may interleave across IDs.
  logic [NID-1:0]          ar_push, ar_pop, ar_empty, ar_ovf;
  logic [NID-1:0][7:0]     ar_head;
  logic [NID-1:0][8:0]     r_cnt_q, r_cnt_d;
  logic [NID-1:0][1:0]     acc_q, acc_d;
  logic [8:0]              beats;
  logic [1:0]              resp_new;
  logic                    rd_fire, orphan_r, rlen_err, rmiss;

  for (genvar g = 0; g < NID; g++) begin : g_arq
    assign ar_push[g] = ar_hs && (monitor.arid == AXI4_ID_WIDTH'(g));
    axi4_mon_fifo #(.WIDTH(8), .DEPTH(MAX_PER_ID)) u_arq (
      .clk_i(clk), .rstn_i(rstn), .push_i(ar_push[g]), .din_i(monitor.arlen),
      .pop_i(ar_pop[g]), .dout_o(ar_head[g]), .full_o(unused_ar_full[g]),
      .empty_o(ar_empty[g]), .ovf_o(ar_ovf[g]));
  end

  always_comb begin
    r_cnt_d  = r_cnt_q;
    acc_d    = acc_q;
    ar_pop   = '0;
    rd_fire  = 1'b0;
    orphan_r = 1'b0;
    rlen_err = 1'b0;
    rmiss    = 1'b0;
    beats    = r_cnt_q[monitor.rid] + 9'd1;
    resp_new = resp_max(acc_q[monitor.rid], monitor.rresp);
    if (r_hs) begin
      if (ar_empty[monitor.rid]) orphan_r = 1'b1;
      else if (monitor.rlast) begin
        rlen_err = (beats != {1'b0, ar_head[monitor.rid]} + 9'd1);
        ar_pop[monitor.rid]  = 1'b1;
        r_cnt_d[monitor.rid] = '0;
        acc_d[monitor.rid]   = '0;
        rd_fire = 1'b1;
      end else begin
        rmiss = (beats == {1'b0, ar_head[monitor.rid]} + 9'd1);
        r_cnt_d[monitor.rid] = beats;
        acc_d[monitor.rid]   = resp_new;
      end
    end
  end

  logic [ERR_W-1:0] err_set, err_q;
  always_comb begin
    err_set = '0;
    err_set[ERR_WLAST]         = wlen_err;
    err_set[ERR_RLAST]         = rlen_err;
    err_set[ERR_ORPHAN_B]      = orphan_b;
    err_set[ERR_ORPHAN_R]      = orphan_r;
    err_set[ERR_OVERFLOW]      = aw_ovf || wb_ovf || (|ar_ovf) || bpend_ovf;
    err_set[ERR_RLAST_MISSING] = rmiss;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_cnt_q      <= '0;
      b_pend_q     <= '0;
      r_cnt_q      <= '0;
      acc_q        <= '0;
      err_q        <= '0;
      wr_done      <= 1'b0;
      wr_done_id   <= '0;
      wr_done_resp <= '0;
      rd_done      <= 1'b0;
      rd_done_id   <= '0;
      rd_done_resp <= '0;
    end else begin
      if (w_hs) w_cnt_q <= monitor.wlast ? 9'd0 : w_cnt_q + 9'd1;
      b_pend_q <= b_pend_d;
      r_cnt_q  <= r_cnt_d;
      acc_q    <= acc_d;
      err_q    <= (err_clr ? '0 : err_q) | err_set;
      wr_done  <= b_ok;
      rd_done  <= rd_fire;
      if (b_ok) begin
        wr_done_id   <= monitor.bid;
        wr_done_resp <= monitor.bresp;
      end
      if (rd_fire) begin
        rd_done_id   <= monitor.rid;
        rd_done_resp <= resp_new;
      end
    end
  end

  assign err = err_q;
endmodule

// File: doc/axi4_txn_monitor.md
Name: axi4_txn_monitor

Overview:
- Passive AXI4 transaction monitor. It observes one axi4_if through the monitor modport and reconstructs complete write and read bursts.
- Emits one-cycle completion strobes carrying ID and response.
- Raises sticky protocol-error flags for burst-length mismatch, orphan responses and tracking overflow.
- Sits beside any master/slave pair in the bench or SoC. It never drives the bus.

Parameters:
- AXI4_ADDRESS_WIDTH, 32, interface address width (carried through, not checked)
- AXI4_DATA_WIDTH, 128, interface data width (carried through)
- AXI4_ID_WIDTH, 4, ID width; per-ID tracking has 2**AXI4_ID_WIDTH slots
- MAX_OUTSTANDING, 8, depth of the AW FIFO and the W-burst FIFO
- MAX_PER_ID, 4, max outstanding bursts tracked per ID per direction

Ports:
- clk  input  1  clock
- rstn  input  1  reset; asynchronous assert, active-low
- monitor  interface(axi4_if.monitor)  -  observed bus; all AXI inputs are sampled on rising clk
- err_clr  input  1  clears all sticky error flags
- wr_done  output  1  one-cycle pulse: write burst completed (B handshake)
- wr_done_id  output  AXI4_ID_WIDTH  BID of completed write
- wr_done_resp  output  2  BRESP of completed write
- rd_done  output  1  one-cycle pulse: read burst completed (RLAST handshake)
- rd_done_id  output  AXI4_ID_WIDTH  RID of completed read
- rd_done_resp  output  2  numeric max of RRESP over all beats of the burst
- err  output  6  sticky flags: [0] wlast_len, [1] rlast_len, [2] orphan_b, [3] orphan_r, [4] overflow, [5] early_rlast_missing

Behaviour:
- Reset: all FIFOs, counters and tables cleared. All outputs 0. Reset mid-burst discards all in-flight state; no strobe is issued for it.
- Handshake: a beat counts only on a cycle with xVALID && xREADY.
- Write path:
  - AW handshake pushes {AWID, AWLEN} into the AW FIFO.
  - W beat counter (9 bits) increments per W handshake. On WLAST it pushes the beat count (count+1) into the W-burst FIFO and resets to 0. W data may therefore lead AW.
  - Pairing: when both FIFOs are non-empty, pop one entry from each in the same cycle.
  - If beats != AWLEN+1, set err[0]. In either case increment b_pend[AWID].
- B handshake:
  - If b_pend[BID]==0: set err[2], no strobe.
  - Else decrement b_pend[BID] and drive wr_done=1 with BID/BRESP in the next cycle (registered, latency 1).
- Read path:
  - AR handshake pushes ARLEN into per-ID FIFO ar_q[ARID] (depth MAX_PER_ID).
  - R beat: if ar_q[RID] is empty, set err[3] and ignore the beat.
  - Otherwise increment r_cnt[RID] and resp_acc[RID]=max(resp_acc,RRESP).
  - On RLAST: compare r_cnt+1 against head ARLEN+1; on mismatch set err[1]. Then pop the head, clear r_cnt/resp_acc for that ID, and drive rd_done next cycle.
  - Beat count reaching ARLEN+1 without RLAST sets err[5]. The counter keeps running until RLAST.
  - Interleaving of R beats across IDs is supported.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle is legal even when full.
  - Pairing increment and B decrement on the same ID in one cycle nets to 0.
  - AR push and RLAST pop on the same ID in one cycle is legal.
- Overflow: a push into a full FIFO, or b_pend at MAX_PER_ID being incremented, sets err[4]; the push is dropped.
- Errors: sticky until err_clr. A new error in the same cycle as err_clr remains set.
- Strobes are never back-to-back merged: one wr_done per B and one rd_done per RLAST, each independent.

Decomposition:
- axi4_monitor_pkg holds:
  - resp enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - err bit index constants ERR_WLAST..ERR_RLAST_MISSING
  - ERR_W=6
- Sub-module axi4_mon_fifo: parametrised sync FIFO (WIDTH, DEPTH) with full/empty. Instantiated for the AW FIFO, the W-burst FIFO, and one instance per ID via generate for ar_q.

Test Plan:
- AW id=3 len=3, then 4 W beats with WLAST on the 4th, then B id=3 OKAY -> wr_done=1 for one cycle, id=3, resp=0; err=0.
- 2 W beats with WLAST first, then AW id=1 len=1, then B id=1 SLVERR -> wr_done id=1 resp=2; err=0.
- AW id=0 len=3, only 3 W beats with WLAST -> err[0]=1. After err_clr, err=0.
- AR id=2 len=1 and AR id=5 len=0; R order id2, id5(last), id2(last) with RRESP 0,0,2 -> rd_done id=5 resp=0, then rd_done id=2 resp=2.
- B id=7 with nothing outstanding -> err[2]=1, no wr_done. R id=4 with no AR -> err[3]=1.
- 5 ARs on id=0 with MAX_PER_ID=4 -> err[4]=1. Assert rstn=0 mid-stream -> all outputs 0; a subsequent R id=0 sets err[3].
